ysyx_20020207_lsu: RTL and testbench
====================================

Name: ysyx_20020207_lsu

Overview:
Load/store unit directly downstream of the ALU in the multicycle RV32 core. Accepts the ALU-computed effective address plus store data and access type, and runs one access on AXI4-Lite-style split read/write channels. Does byte-lane steering and write strobes on stores, and lane extraction with sign/zero extension on loads. Returns a single-cycle completion pulse to writeback.

Parameters:
TIMEOUT, 255, bus-wait cycles before a forced error completion; used only with the optional feature.

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request strobe from the ALU stage (addr_valid)
req_ready  out  1  high in IDLE only
req_addr  in  32  effective address (lsu_addr)
req_wdata  in  32  store data (rs2)
req_ren  in  1  load access
req_wen  in  1  store access
req_funct3  in  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
araddr  out  32  read address, word aligned
arvalid  out  1 / arready  in  1
rdata  in  32 / rresp  in  2 / rvalid  in  1 / rready  out  1
awaddr  out  32  write address, word aligned
awvalid  out  1 / awready  in  1
wdata  out  32 / wstrb  out  4 / wvalid  out  1 / wready  in  1
bresp  in  2 / bvalid  in  1 / bready  out  1
lsu_valid  out  1  completion pulse, exactly one cycle
lsu_rdata  out  32  extended load data, valid with lsu_valid
lsu_err  out  1  access fault, valid with lsu_valid

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All bus valids, rready, bready, lsu_valid and lsu_err are 0. lsu_rdata, araddr, awaddr, wdata and wstrb are 0. A reset mid-transaction drops all valids immediately; late responses after reset are not consumed.
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE: when req_valid is high, latch addr, wdata, funct3, ren and wen. req_ready is low from the next cycle.
- Routing from IDLE:
  - Load goes to RADDR.
  - Store goes to WREQ.
  - Neither ren nor wen goes to DONE with rdata 0 and err 0 (non-memory instructions complete in 1 cycle).
  - Both ren and wen, or a misaligned access, goes to DONE with err 1 and no bus activity.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- RADDR: arvalid=1, araddr={addr[31:2],2'b00}. Held stable until arready is sampled high, then go to RDATA.
- RDATA: rready=1. On rvalid:
  - sh = rdata >> (8*addr[1:0]).
  - Extend sh by funct3: 000 sign-extends bit 7; 001 sign-extends bit 15; 100/101 zero-extend; 010 passes through.
  - err = (rresp!=0). Go to DONE.
  - Unsupported funct3 values (011, 110, 111) raise err in IDLE.
- WREQ: awvalid and wvalid rise together.
  - wdata = wdata_latched << (8*addr[1:0]).
  - wstrb = 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, 1111 for W.
  - Each valid drops independently after its ready handshake; sticky aw_done/w_done flags track completion.
  - When both are done, go to WRESP. Same-cycle handshakes on both channels are legal.
- WRESP: bready=1. On bvalid, err=(bresp!=0); go to DONE.
- DONE: lsu_valid=1 for exactly one cycle, with lsu_rdata/lsu_err held. Return to IDLE; a new request is accepted the cycle after DONE.
- Latency: minimum load is 4 cycles from req_valid to lsu_valid (accept, RADDR, RDATA, DONE) with zero-wait slave. Minimum store is 4 cycles.
- lsu_rdata holds its value until the next DONE. Stores report rdata 0.
- req_valid outside IDLE is ignored.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: an 8..16-bit wait counter clears on entry to RADDR, RDATA, WREQ and WRESP, and increments each cycle spent there.
- When the counter reaches TIMEOUT: drop all valids/readies, go to DONE with err 1 and rdata 0.
- Undefined: no counter; the LSU waits indefinitely.

Test Plan:
- LB at addr 0x8000_0003, slave rdata 0x80AA_BBCC, zero wait -> araddr 0x8000_0000; lsu_rdata 0xFFFF_FF80, err 0; lsu_valid 4 cycles after req_valid.
- LHU at 0x8000_0002, rdata 0x1234_F00D -> lsu_rdata 0x0000_1234. LW at 0x8000_0002 -> err 1, arvalid never asserted.
- SB at 0x8000_0001 with wdata 0x0000_00A5 -> awaddr 0x8000_0000, wdata 0x0000_A500, wstrb 0010. Slave delays awready 3 cycles but wready 0 cycles -> exactly one handshake per channel, then bready; one lsu_valid pulse.
- Load with rresp=2'b10 -> lsu_err 1 with lsu_valid. Request with ren=wen=0 -> lsu_valid next+1 cycle, rdata 0, err 0.
- Reset driven low while in RDATA with rvalid never given -> rready/arvalid 0 asynchronously; after release, a new LW at 0x8000_0004 completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT=8: arready held 0 -> lsu_valid with err 1 exactly 8 cycles after entering RADDR; arvalid low afterwards.

Source files
------------

// File: rtl/ysyx_20020207_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ysyx_20020207_lsu : RV32 load/store unit on split AXI4-Lite-style ports   |
// | Optional LSU_TIMEOUT_EN: bus-wait watchdog forcing an error completion.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ysyx_20020207_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_ren,
   input  logic        req_wen,
   input  logic [2:0]  req_funct3,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic        lsu_valid,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WREQ  = 3'd3,
      S_WRESP = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_off;
   logic [2:0]  r_funct3;
   logic        r_aw_done;
   logic        r_w_done;
   logic        w_mem;
   logic        w_misal;
   logic        w_unsup;
   logic        w_bad;
   logic        w_fin_err;
   logic [31:0] w_fin_rdata;
   logic [31:0] w_shift;
   logic [31:0] w_ext;
   logic        w_tmo;

   // Faults are resolved at accept time so a bad access never touches the bus
   assign w_mem   = req_ren | req_wen;
   assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_unsup = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
   assign w_bad   = (req_ren & req_wen) | (w_mem & (w_misal | w_unsup));

   assign w_shift = rdata >> {r_off, 3'b000};

   always_comb begin
      w_ext = w_shift;
      case (r_funct3)
         3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ext = {24'd0, w_shift[7:0]};
         3'b101:  w_ext = {16'd0, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] r_wait;
   logic        w_wait_st;

   assign w_wait_st = (r_state == S_RADDR) || (r_state == S_RDATA) ||
                      (r_state == S_WREQ)  || (r_state == S_WRESP);
   assign w_tmo     = w_wait_st && (r_wait == c_TO_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wait <= 16'd0;
      end else if (w_next != r_state) begin
         r_wait <= 16'd0;
      end else if (w_wait_st) begin
         r_wait <= r_wait + 16'd1;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
   assign w_tmo            = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_fin_err   = 1'b0;
      w_fin_rdata = 32'd0;
      req_ready   = 1'b0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      awvalid     = 1'b0;
      wvalid      = 1'b0;
      bready      = 1'b0;
      lsu_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_bad) begin
                  w_next    = S_DONE;
                  w_fin_err = 1'b1;
               end else if (req_ren) begin
                  w_next = S_RADDR;
               end else if (req_wen) begin
                  w_next = S_WREQ;
               end else begin
                  w_next = S_DONE;
               end
            end
         end
         S_RADDR: begin
            arvalid = 1'b1;
            if (arready) w_next = S_RDATA;
         end
         S_RDATA: begin
            rready = 1'b1;
            if (rvalid) begin
               w_next      = S_DONE;
               w_fin_rdata = w_ext;
               w_fin_err   = |rresp;
            end
         end
         S_WREQ: begin
            awvalid = !r_aw_done;
            wvalid  = !r_w_done;
            if ((r_aw_done | awready) && (r_w_done | wready)) w_next = S_WRESP;
         end
         S_WRESP: begin
            bready = 1'b1;
            if (bvalid) begin
               w_next    = S_DONE;
               w_fin_err = |bresp;
            end
         end
         S_DONE: begin
            lsu_valid = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Watchdog withdraws every handshake so nothing is accepted on the way out
      if (w_tmo) begin
         w_next      = S_DONE;
         w_fin_err   = 1'b1;
         w_fin_rdata = 32'd0;
         arvalid     = 1'b0;
         rready      = 1'b0;
         awvalid     = 1'b0;
         wvalid      = 1'b0;
         bready      = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_off     <= 2'd0;
         r_funct3  <= 3'd0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         araddr    <= 32'd0;
         awaddr    <= 32'd0;
         wdata     <= 32'd0;
         wstrb     <= 4'd0;
         lsu_rdata <= 32'd0;
         lsu_err   <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && req_valid) begin
            r_off    <= req_addr[1:0];
            r_funct3 <= req_funct3;
            if (!w_bad && req_ren) araddr <= {req_addr[31:2], 2'b00};
            if (!w_bad && !req_ren && req_wen) begin
               awaddr <= {req_addr[31:2], 2'b00};
               wdata  <= req_wdata << {req_addr[1:0], 3'b000};
               case (req_funct3[1:0])
                  2'b00:   wstrb <= 4'b0001 << req_addr[1:0];
                  2'b01:   wstrb <= 4'b0011 << req_addr[1:0];
                  default: wstrb <= 4'b1111;
               endcase
            end
         end
         if (r_state == S_WREQ) begin
            if (awvalid && awready) r_aw_done <= 1'b1;
            if (wvalid && wready)   r_w_done  <= 1'b1;
         end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (w_next == S_DONE) begin
            lsu_rdata <= w_fin_rdata;
            lsu_err   <= w_fin_err;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_20020207_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ysyx_20020207_lsu : self-checking bench for the load/store unit        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ysyx_20020207_lsu;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_ren, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic [31:0] araddr, rdata, awaddr, wdata, lsu_rdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready;
   logic        wvalid, wready, bvalid, bready, lsu_valid, lsu_err;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   int vectors    = 0;
   int miscompares = 0;

   // Results of the most recent run_op
   logic        o_got, o_err, after_ok;
   int          o_lat, ar_hs, aw_hs, w_hs, r_hs, b_hs, ar_seen, aw_seen;
   logic [31:0] o_rd, cap_araddr, cap_awaddr, cap_wdata;
   logic [3:0]  cap_wstrb;

   always #5 clock = ~clock;

   ysyx_20020207_lsu #(.TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ren(req_ren), .req_wen(req_wen), .req_funct3(req_funct3),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .lsu_valid(lsu_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err)
   );

   // Reference: pick the addressed bytes, then widen them arithmetically
   function automatic logic [31:0] load_model(logic [31:0] word, logic [1:0] off, logic [2:0] f3);
      logic [31:0] s;
      logic [7:0]  b0, b1;
      s  = word >> (8 * off);
      b0 = s[7:0];
      b1 = s[15:8];
      case (f3)
         3'b000:  return 32'($signed(b0));
         3'b001:  return 32'($signed({b1, b0}));
         3'b100:  return {24'd0, b0};
         3'b101:  return {16'd0, b1, b0};
         default: return s;
      endcase
   endfunction

   function automatic logic is_bad(logic [31:0] a, logic ren, logic wen, logic [2:0] f3);
      logic [1:0] lo;
      lo = a[1:0];
      if (ren && wen) return 1'b1;
      if (!ren && !wen) return 1'b0;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if ((f3 == 3'd1 || f3 == 3'd5) && (lo % 2 != 0)) return 1'b1;
      if (f3 == 3'd2 && lo != 0) return 1'b1;
      return 1'b0;
   endfunction

   // Issue one request at a negedge and act as the bus slave until completion
   task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic ren,
                         input logic wen, input logic [2:0] f3, input logic [31:0] srd,
                         input logic [1:0] srr, input logic [1:0] sbr,
                         input int ard, input int awd, input int wdd);
      int arc, awc, wc;
      arc = 0; awc = 0; wc = 0;
      o_got = 0; o_lat = -1; o_rd = 'x; o_err = 'x; after_ok = 0;
      ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0; ar_seen = 0; aw_seen = 0;
      cap_araddr = 'x; cap_awaddr = 'x; cap_wdata = 'x; cap_wstrb = 'x;
      req_addr = a; req_wdata = wd; req_ren = ren; req_wen = wen; req_funct3 = f3;
      req_valid = 1'b1;
      for (int c = 1; c <= 60 && !o_got; c++) begin
         @(negedge clock);
         req_valid = 1'b0;
         if (lsu_valid) begin
            o_got = 1; o_lat = c; o_rd = lsu_rdata; o_err = lsu_err;
         end
         arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
         if (arvalid) begin
            ar_seen++;
            if (arc >= ard) begin arready = 1; ar_hs++; cap_araddr = araddr; end
            arc++;
         end
         if (rready) begin rvalid = 1; rdata = srd; rresp = srr; r_hs++; end
         if (awvalid) begin
            aw_seen++;
            if (awc >= awd) begin awready = 1; aw_hs++; cap_awaddr = awaddr; end
            awc++;
         end
         if (wvalid) begin
            if (wc >= wdd) begin wready = 1; w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; end
            wc++;
         end
         if (bready) begin bvalid = 1; bresp = sbr; b_hs++; end
      end
      if (o_got) begin
         @(negedge clock);
         after_ok = !lsu_valid && req_ready;
      end
   endtask

   task automatic test_reset();
      reset = 0; req_valid = 0; req_addr = 0; req_wdata = 0; req_ren = 0; req_wen = 0;
      req_funct3 = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0; awready = 0;
      wready = 0; bresp = 0; bvalid = 0;
      repeat (3) @(negedge clock);
      vectors++;
      if ({arvalid, rready, awvalid, wvalid, bready, lsu_valid, lsu_err} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {arvalid, rready, awvalid, wvalid, bready, lsu_valid, lsu_err});
      end
      vectors++;
      if ({araddr, awaddr, wdata, lsu_rdata} !== 128'd0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h %h expected all 0", araddr, awaddr, wdata, lsu_rdata);
      end
      vectors++;
      if (wstrb !== 4'd0) begin
         miscompares++; $display("FAIL reset_wstrb: got %b expected 0000", wstrb);
      end
      reset = 1;
      @(negedge clock);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_lb();
      run_op(32'h8000_0003, 32'h0, 1, 0, 3'b000, 32'h80AA_BBCC, 2'b00, 2'b00, 0, 0, 0);
      vectors++;
      if (cap_araddr !== 32'h8000_0000) begin
         miscompares++; $display("FAIL lb_araddr: got %h expected 80000000", cap_araddr);
      end
      vectors++;
      if (o_rd !== 32'hFFFF_FF80 || o_err !== 1'b0) begin
         miscompares++; $display("FAIL lb_data: got %h/%b expected ffffff80/0", o_rd, o_err);
      end
      // accept, RADDR, RDATA, DONE: pulse seen after the third edge from accept
      vectors++;
      if (o_lat !== 3 || !after_ok) begin
         miscompares++; $display("FAIL lb_latency: got %0d/%b expected 3/1", o_lat, after_ok);
      end
   endtask

   task automatic test_lhu_lw();
      run_op(32'h8000_0002, 32'h0, 1, 0, 3'b101, 32'h1234_F00D, 2'b00, 2'b00, 0, 0, 0);
      vectors++;
      if (o_rd !== 32'h0000_1234 || o_err !== 1'b0 || o_lat !== 3) begin
         miscompares++;
         $display("FAIL lhu: got %h/%b/%0d expected 00001234/0/3", o_rd, o_err, o_lat);
      end
      run_op(32'h8000_0002, 32'h0, 1, 0, 3'b010, 32'h1234_F00D, 2'b00, 2'b00, 0, 0, 0);
      vectors++;
      if (o_err !== 1'b1 || ar_seen !== 0 || o_lat !== 1) begin
         miscompares++;
         $display("FAIL lw_misaligned: got err %b arvalid_cycles %0d lat %0d expected 1/0/1",
                  o_err, ar_seen, o_lat);
      end
   endtask

   task automatic test_sb_delayed();
      run_op(32'h8000_0001, 32'h0000_00A5, 0, 1, 3'b000, 32'h0, 2'b00, 2'b00, 0, 3, 0);
      vectors++;
      if (cap_awaddr !== 32'h8000_0000 || cap_wdata !== 32'h0000_A500 || cap_wstrb !== 4'b0010) begin
         miscompares++;
         $display("FAIL sb_bus: got %h %h %b expected 80000000 0000a500 0010",
                  cap_awaddr, cap_wdata, cap_wstrb);
      end
      vectors++;
      if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1 || aw_seen !== 4) begin
         miscompares++;
         $display("FAIL sb_handshakes: got aw %0d w %0d b %0d awcyc %0d expected 1 1 1 4",
                  aw_hs, w_hs, b_hs, aw_seen);
      end
      vectors++;
      if (o_lat !== 6 || o_err !== 1'b0 || o_rd !== 32'h0 || !after_ok) begin
         miscompares++;
         $display("FAIL sb_done: got %0d/%b/%h/%b expected 6/0/0/1", o_lat, o_err, o_rd, after_ok);
      end
   endtask

   task automatic test_errors_nonmem();
      run_op(32'h8000_0010, 32'h0, 1, 0, 3'b010, 32'h5555_AAAA, 2'b10, 2'b00, 0, 0, 0);
      vectors++;
      if (o_err !== 1'b1 || o_lat !== 3) begin
         miscompares++; $display("FAIL rresp_err: got %b/%0d expected 1/3", o_err, o_lat);
      end
      run_op(32'h1234_5677, 32'hFFFF_FFFF, 0, 0, 3'b111, 32'h0, 2'b00, 2'b00, 0, 0, 0);
      vectors++;
      if (o_rd !== 32'h0 || o_err !== 1'b0 || o_lat !== 1 || ar_seen !== 0 || aw_seen !== 0) begin
         miscompares++;
         $display("FAIL nonmem: got %h/%b/%0d bus %0d %0d expected 0/0/1 bus 0 0",
                  o_rd, o_err, o_lat, ar_seen, aw_seen);
      end
      run_op(32'h8000_0000, 32'h0, 1, 1, 3'b010, 32'h0, 2'b00, 2'b00, 0, 0, 0);
      vectors++;
      if (o_err !== 1'b1 || o_lat !== 1 || ar_seen !== 0 || aw_seen !== 0) begin
         miscompares++;
         $display("FAIL ren_wen: got %b/%0d bus %0d %0d expected 1/1 bus 0 0",
                  o_err, o_lat, ar_seen, aw_seen);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      req_addr = 32'h8000_0008; req_ren = 1; req_wen = 0; req_funct3 = 3'b010; req_valid = 1;
      @(negedge clock);
      req_valid = 0; arready = 1;
      @(negedge clock);
      arready = 0;
      vectors++;
      if (rready !== 1'b1) begin
         miscompares++; $display("FAIL mid_rdata: got rready %b expected 1", rready);
      end
      #2 reset = 0;
      #1;
      vectors++;
      if (rready !== 1'b0 || arvalid !== 1'b0 || lsu_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_async: got %b%b%b expected 000", rready, arvalid, lsu_valid);
      end
      rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      vectors++;
      if (rready !== 1'b0 || lsu_valid !== 1'b0) begin
         miscompares++; $display("FAIL mid_late: got %b%b expected 00", rready, lsu_valid);
      end
      rvalid = 0;
      d = $urandom;
      run_op(32'h8000_0004, 32'h0, 1, 0, 3'b010, d, 2'b00, 2'b00, 0, 0, 0);
      vectors++;
      if (o_rd !== d || o_err !== 1'b0 || o_lat !== 3 || cap_araddr !== 32'h8000_0004) begin
         miscompares++;
         $display("FAIL mid_recover: got %h/%b/%0d/%h expected %h/0/3/80000004",
                  o_rd, o_err, o_lat, cap_araddr, d);
      end
   endtask

   task automatic test_random();
      int lf[6] = '{0, 1, 2, 4, 5, 3};
      for (int i = 0; i < 60; i++) begin
         int kind, ard, awd, wdd, e_lat, e_ar, e_aw, e_w, e_b, sz;
         logic [31:0] a, wd, srd, e_rd, e_wdata;
         logic [3:0]  e_strb;
         logic [2:0]  f3;
         logic [1:0]  srr, sbr;
         logic        ren, wen, bad, e_err, ld, st;
         kind = $urandom_range(0, 9);
         a = $urandom; wd = $urandom; srd = $urandom;
         ard = $urandom_range(0, 3); awd = $urandom_range(0, 3); wdd = $urandom_range(0, 3);
         srr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         sbr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         ren = (kind == 1) || (kind >= 2 && kind <= 5);
         wen = (kind == 1) || (kind >= 6);
         if (kind >= 2 && kind <= 5) f3 = 3'(lf[$urandom_range(0, 5)]);
         else if (kind >= 6)         f3 = 3'($urandom_range(0, 2));
         else                        f3 = 3'($urandom_range(0, 7));
         if (kind >= 6 && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run_op(a, wd, ren, wen, f3, srd, srr, sbr, ard, awd, wdd);
         bad = is_bad(a, ren, wen, f3);
         ld = ren && !wen && !bad;
         st = wen && !ren && !bad;
         e_lat = ld ? 3 + ard : st ? 3 + ((awd > wdd) ? awd : wdd) : 1;
         e_err = bad || (ld && srr != 0) || (st && sbr != 0);
         e_rd  = ld ? load_model(srd, a[1:0], f3) : 32'd0;
         e_ar = ld ? 1 : 0; e_aw = st ? 1 : 0; e_w = st ? 1 : 0; e_b = st ? 1 : 0;
         sz = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
         e_strb = 4'd0;
         for (int k = 0; k < sz; k++) e_strb[int'(a[1:0]) + k] = 1'b1;
         e_wdata = wd << (8 * a[1:0]);
         vectors++;
         if (o_lat !== e_lat || !after_ok) begin
            miscompares++;
            $display("FAIL rnd%0d_latency: got %0d/%b expected %0d/1", i, o_lat, after_ok, e_lat);
         end
         vectors++;
         if (o_err !== e_err) begin
            miscompares++; $display("FAIL rnd%0d_err: got %b expected %b", i, o_err, e_err);
         end
         if (!e_err || !ld) begin
            vectors++;
            if (o_rd !== e_rd) begin
               miscompares++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, o_rd, e_rd);
            end
         end
         vectors++;
         if (ar_hs !== e_ar || aw_hs !== e_aw || w_hs !== e_w || b_hs !== e_b) begin
            miscompares++;
            $display("FAIL rnd%0d_handshakes: got ar%0d aw%0d w%0d b%0d expected ar%0d aw%0d w%0d b%0d",
                     i, ar_hs, aw_hs, w_hs, b_hs, e_ar, e_aw, e_w, e_b);
         end
         if (ld) begin
            vectors++;
            if (cap_araddr !== {a[31:2], 2'b00}) begin
               miscompares++;
               $display("FAIL rnd%0d_araddr: got %h expected %h", i, cap_araddr, {a[31:2], 2'b00});
            end
         end
         if (st) begin
            vectors++;
            if (cap_awaddr !== {a[31:2], 2'b00} || cap_wdata !== e_wdata || cap_wstrb !== e_strb) begin
               miscompares++;
               $display("FAIL rnd%0d_write: got %h %h %b expected %h %h %b", i, cap_awaddr,
                        cap_wdata, cap_wstrb, {a[31:2], 2'b00}, e_wdata, e_strb);
            end
         end
      end
   endtask

`ifdef LSU_TIMEOUT_EN
   task automatic test_timeout();
      run_op(32'h8000_0000, 32'h0, 1, 0, 3'b010, 32'h1111_2222, 2'b00, 2'b00, 1000, 0, 0);
      // RADDR entered at the accept edge, DONE eight edges later
      vectors++;
      if (o_lat !== 9 || o_err !== 1'b1 || o_rd !== 32'h0 || ar_hs !== 0) begin
         miscompares++;
         $display("FAIL timeout: got %0d/%b/%h/%0d expected 9/1/0/0", o_lat, o_err, o_rd, ar_hs);
      end
      vectors++;
      if (arvalid !== 1'b0 || !after_ok) begin
         miscompares++; $display("FAIL timeout_after: got %b/%b expected 0/1", arvalid, after_ok);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_lb();
      test_lhu_lw();
      test_sb_delayed();
      test_errors_nonmem();
      test_reset_mid();
      test_random();
`ifdef LSU_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
